uart_tx_buffer: RTL

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_buffer_if.sv | 39 +++
 rtl/sync_fifo.sv | 81 ++++++++
 rtl/uart_tx_buffer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: frame data width, the transmit-buffer FSM state
// type and the width of the NEWD hold counter.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    // Wide enough for NEWD_LEN up to 15.
    localparam int unsigned NEWD_CNT_W = 4;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;
    typedef logic [NEWD_CNT_W-1:0]     newd_cnt_t;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_LOAD      = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer_if
// Bundles the byte-write side, the FIFO status flags and the transmitter
// handshake of uart_tx_buffer.
//   slave  : used by uart_tx_buffer (drives status, TDATA, NEWD, BUSY)
//   master : used by the producer / transmitter side
// Signals: WR_DATA, WR_EN, CLR_OVF, DONETX  (into the buffer)
//          FULL, EMPTY, COUNT, OVERFLOW, TDATA, NEWD, BUSY (out of the buffer)
// ---------------------------------------------------------------------------
interface uart_tx_buffer_if #(
    parameter int unsigned DEPTH = 16
);
    import uart_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    uart_byte_t    WR_DATA;
    logic          WR_EN;
    logic          CLR_OVF;
    logic          DONETX;
    logic          FULL;
    logic          EMPTY;
    logic [CW-1:0] COUNT;
    logic          OVERFLOW;
    uart_byte_t    TDATA;
    logic          NEWD;
    logic          BUSY;

    modport slave (
        input  WR_DATA, WR_EN, CLR_OVF, DONETX,
        output FULL, EMPTY, COUNT, OVERFLOW, TDATA, NEWD, BUSY
    );

    modport master (
        output WR_DATA, WR_EN, CLR_OVF, DONETX,
        input  FULL, EMPTY, COUNT, OVERFLOW, TDATA, NEWD, BUSY
    );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock circular FIFO, power-of-two DEPTH, with sticky overflow flag.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_data, wr_en      push side
//   rd_en, rd_data      pop side (rd_data is the current head, show-ahead)
//   full, empty, count  status, derived from the registered count only
//   clr_ovf, overflow   sticky flag set by a dropped write
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clr_ovf,
    output logic                     overflow
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rptr];

    // A pop in the same cycle frees a slot, so a write while full is
    // accepted when it coincides with a pop.
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign drop    = wr_en && !do_push;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A dropped write wins over a simultaneous clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer
// Byte FIFO in front of a UART transmitter. Pops one byte at a time, presents
// it on TDATA with a NEWD request lasting NEWD_LEN cycles, then waits for a
// rising edge of DONETX before taking the next byte.
// Ports:
//   CLK, RST_N  clock, async active-low reset
//   bus         uart_tx_buffer_if.slave (write side, status, UART handshake)
// ---------------------------------------------------------------------------
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned NEWD_LEN = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    uart_tx_buffer_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    tx_state_t     state;
    tx_state_t     state_d;
    newd_cnt_t     newd_cnt;
    newd_cnt_t     newd_cnt_d;
    uart_byte_t    tdata_q;
    uart_byte_t    head;
    logic          donetx_q;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_ovf;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .wr_data  (bus.WR_DATA),
        .wr_en    (bus.WR_EN),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .clr_ovf  (bus.CLR_OVF),
        .overflow (fifo_ovf)
    );

    assign bus.FULL     = fifo_full;
    assign bus.EMPTY    = fifo_empty;
    assign bus.COUNT    = fifo_count;
    assign bus.OVERFLOW = fifo_ovf;
    assign bus.TDATA    = tdata_q;

    // State register plus the byte register and DONETX history it controls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= TX_IDLE;
            newd_cnt <= '0;
            tdata_q  <= '0;
            donetx_q <= 1'b0;
        end else begin
            state    <= state_d;
            newd_cnt <= newd_cnt_d;
            donetx_q <= bus.DONETX;
            if (pop) begin
                tdata_q <= head;
            end
        end
    end

    // Next state. donetx_q tracks DONETX in every state, so a level that is
    // already high when WAIT_DONE is entered never looks like an edge.
    always_comb begin
        state_d    = state;
        newd_cnt_d = newd_cnt;
        pop        = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    newd_cnt_d = '0;
                    state_d    = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (newd_cnt == NEWD_CNT_W'(NEWD_LEN - 1)) begin
                    state_d = TX_WAIT_DONE;
                end else begin
                    newd_cnt_d = newd_cnt + 1'b1;
                end
            end
            TX_WAIT_DONE: begin
                if (bus.DONETX && !donetx_q) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        bus.NEWD = 1'b0;
        bus.BUSY = 1'b0;
        case (state)
            TX_LOAD: begin
                bus.NEWD = 1'b1;
                bus.BUSY = 1'b1;
            end
            TX_WAIT_DONE: begin
                bus.BUSY = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
